// File: rtl/puf_cmd_pkg.sv
// Shared command/status encodings and FSM state type for the PUF command controller.
package puf_cmd_pkg;

  localparam int CH_BITS = 4;
  localparam int OVR_W   = 8;

  localparam logic [3:0] CMD_STIM   = 4'h1;
  localparam logic [3:0] CMD_READ   = 4'h2;
  localparam logic [3:0] CMD_STATUS = 4'h3;

  localparam logic [7:0] ST_BAD_OP  = 8'hE1;
  localparam logic [7:0] ST_BAD_CH  = 8'hE2;
  localparam logic [7:0] ST_TMO     = 8'hE3;
  localparam logic [7:0] ST_BAD_CNT = 8'hE4;
  localparam logic [7:0] ST_NO_RESP = 8'hE5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_START,
    S_WAIT,
    S_REPLY
  } state_t;

endpackage

// File: rtl/puf_cmd_ctrl_if.sv
// Frame and PUF-channel bundle between the SPI frame receiver/transmitter, the PUFs and the controller.
interface puf_cmd_ctrl_if #(
  parameter int N_PUF  = 2,
  parameter int RESP_W = 128,
  parameter int OP_W   = 8,
  parameter int CNT_W  = 16
);
  localparam int FRAME_W = OP_W + RESP_W;

  logic [FRAME_W-1:0]      RX_FRAME;
  logic                    RX_VALID;
  logic [N_PUF-1:0]        PUF_DONE;
  logic [N_PUF*RESP_W-1:0] PUF_RESP;
  logic [N_PUF-1:0]        PUF_START;
  logic [CNT_W-1:0]        PUF_CNT;
  logic [FRAME_W-1:0]      TX_FRAME;
  logic                    TX_VALID;
  logic                    BUSY;

  // master: the controller; slave: the SPI/PUF side it talks to
  modport master (
    input  RX_FRAME, RX_VALID, PUF_DONE, PUF_RESP,
    output PUF_START, PUF_CNT, TX_FRAME, TX_VALID, BUSY
  );

  modport slave (
    output RX_FRAME, RX_VALID, PUF_DONE, PUF_RESP,
    input  PUF_START, PUF_CNT, TX_FRAME, TX_VALID, BUSY
  );

endinterface

// File: rtl/puf_resp_bank.sv
// Per-channel response capture registers with valid bits; data is never reset, only the valid bits.
module puf_resp_bank
  import puf_cmd_pkg::*;
#(
  parameter int N_PUF  = 2,
  parameter int RESP_W = 128
) (
  input  logic               CLK,
  input  logic               clr,
  input  logic               cap,
  input  logic [CH_BITS-1:0] cap_ch,
  input  logic [RESP_W-1:0]  cap_data,
  input  logic [CH_BITS-1:0] rd_ch,
  output logic [RESP_W-1:0]  rd_data,
  output logic [N_PUF-1:0]   valid
);

  logic [RESP_W-1:0] bank [N_PUF];

  always_ff @(posedge CLK) begin
    if (clr) begin
      valid <= '0;
    end else if (cap) begin
      for (int c = 0; c < N_PUF; c++) begin
        if (cap_ch == CH_BITS'(c)) valid[c] <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (cap) begin
      for (int c = 0; c < N_PUF; c++) begin
        if (cap_ch == CH_BITS'(c)) bank[c] <= cap_data;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int c = 0; c < N_PUF; c++) begin
      if (rd_ch == CH_BITS'(c)) rd_data = bank[c];
    end
  end

endmodule

// File: rtl/puf_cmd_ctrl.sv
// Frame-driven command controller: decodes STIM/READ/STATUS, launches PUF runs with a timeout
// guard, banks responses and returns one reply frame per accepted command.
module puf_cmd_ctrl
  import puf_cmd_pkg::*;
#(
  parameter int N_PUF   = 2,
  parameter int RESP_W  = 128,
  parameter int OP_W    = 8,
  parameter int CNT_W   = 16,
  parameter int TMO_CYC = 1048575
) (
  input logic            CLK,
  input logic            RESET,
  puf_cmd_ctrl_if.master bus
);

  localparam int FRAME_W = OP_W + RESP_W;
  localparam int TMO_W   = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

  state_t             state;
  logic [OP_W-1:0]    op_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [TMO_W-1:0]   tmo_q;
  logic [OVR_W-1:0]   ovr_q;
  logic [FRAME_W-1:0] tx_frame_q;
  logic [CNT_W-1:0]   puf_cnt_q;

  logic [3:0]         cmd;
  logic [CH_BITS-1:0] ch;
  logic [N_PUF-1:0]   ch_mask;
  logic [N_PUF-1:0]   valid;
  logic [RESP_W-1:0]  rd_data;
  logic [RESP_W-1:0]  resp_sel;
  logic [RESP_W-1:0]  stat_pay;
  logic [7:0]         dec_st;
  logic               dec_err;
  logic               done_sel;
  logic               rx_drop;
  logic [OVR_W-1:0]   ovr_inc;

  assign cmd      = op_q[7:4];
  assign ch       = op_q[3:0];
  assign done_sel = |(bus.PUF_DONE & ch_mask);
  assign rx_drop  = bus.RX_VALID && (state != S_IDLE);
  assign ovr_inc  = (ovr_q == {OVR_W{1'b1}}) ? ovr_q : ovr_q + 1'b1;

  always_comb begin
    ch_mask = '0;
    for (int c = 0; c < N_PUF; c++) ch_mask[c] = (ch == CH_BITS'(c));
  end

  always_comb begin
    resp_sel = '0;
    for (int c = 0; c < N_PUF; c++) begin
      if (ch_mask[c]) resp_sel = bus.PUF_RESP[c*RESP_W +: RESP_W];
    end
  end

  always_comb begin
    stat_pay                      = '0;
    stat_pay[N_PUF-1:0]           = valid;
    stat_pay[N_PUF+OVR_W-1:N_PUF] = ovr_q;
  end

  // Error checks in priority order; the first failing one names the status reply
  always_comb begin
    dec_st  = 8'h00;
    dec_err = 1'b1;
    if (!(cmd == CMD_STIM || cmd == CMD_READ || cmd == CMD_STATUS))
      dec_st = ST_BAD_OP;
    else if (cmd != CMD_STATUS && {1'b0, ch} >= 5'(N_PUF))
      dec_st = ST_BAD_CH;
    else if (cmd == CMD_STIM && cnt_q == '0)
      dec_st = ST_BAD_CNT;
    else if (cmd == CMD_READ && !(|(valid & ch_mask)))
      dec_st = ST_NO_RESP;
    else
      dec_err = 1'b0;
  end

  // Command register: loaded only when a frame is accepted in IDLE
  always_ff @(posedge CLK) begin
    if (state == S_IDLE && bus.RX_VALID) begin
      op_q  <= bus.RX_FRAME[FRAME_W-1 -: OP_W];
      cnt_q <= bus.RX_FRAME[CNT_W-1:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= S_IDLE;
      tx_frame_q <= '0;
      puf_cnt_q  <= CNT_W'(1);
      ovr_q      <= '0;
      tmo_q      <= '0;
    end else begin
      if (rx_drop) ovr_q <= ovr_inc;
      unique case (state)
        S_IDLE: begin
          if (bus.RX_VALID) state <= S_DECODE;
        end
        S_DECODE: begin
          if (dec_err) begin
            tx_frame_q <= {OP_W'(dec_st), {RESP_W{1'b0}}};
            state      <= S_REPLY;
          end else if (cmd == CMD_STIM) begin
            puf_cnt_q <= cnt_q;
            state     <= S_START;
          end else if (cmd == CMD_READ) begin
            tx_frame_q <= {op_q, rd_data};
            state      <= S_REPLY;
          end else begin
            // Snapshot is reported and the counter restarts; a drop on this very edge still counts
            tx_frame_q <= {op_q, stat_pay};
            ovr_q      <= rx_drop ? OVR_W'(1) : '0;
            state      <= S_REPLY;
          end
        end
        S_START: begin
          tmo_q <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (done_sel) begin
            tx_frame_q <= {op_q, resp_sel};
            state      <= S_REPLY;
          end else if (tmo_q == TMO_W'(TMO_CYC - 1)) begin
            tx_frame_q <= {OP_W'(ST_TMO), {RESP_W{1'b0}}};
            state      <= S_REPLY;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_REPLY: begin
          puf_cnt_q <= CNT_W'(1);
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  puf_resp_bank #(
    .N_PUF  (N_PUF),
    .RESP_W (RESP_W)
  ) u_bank (
    .CLK      (CLK),
    .clr      (RESET),
    .cap      ((state == S_WAIT) && done_sel),
    .cap_ch   (ch),
    .cap_data (resp_sel),
    .rd_ch    (ch),
    .rd_data  (rd_data),
    .valid    (valid)
  );

  assign bus.PUF_START = (state == S_START) ? ch_mask : '0;
  assign bus.PUF_CNT   = puf_cnt_q;
  assign bus.TX_FRAME  = tx_frame_q;
  assign bus.TX_VALID  = (state == S_REPLY);
  assign bus.BUSY      = (state != S_IDLE);

endmodule

// File: tb/tb_puf_cmd_ctrl.sv
// Directed plus randomized command sequences for puf_cmd_ctrl, checked against a transaction-level model.
module tb_puf_cmd_ctrl;

  localparam int N   = 2;
  localparam int RW  = 128;
  localparam int OW  = 8;
  localparam int CW  = 16;
  localparam int TMO = 8;
  localparam int FW  = OW + RW;

  logic CLK = 1'b0;
  logic RESET;

  puf_cmd_ctrl_if #(.N_PUF(N), .RESP_W(RW), .OP_W(OW), .CNT_W(CW)) bus ();

  puf_cmd_ctrl #(
    .N_PUF   (N),
    .RESP_W  (RW),
    .OP_W    (OW),
    .CNT_W   (CW),
    .TMO_CYC (TMO)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  logic [RW-1:0] m_bank [N];
  bit            m_valid [N];
  int            m_ovr;

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive_puf(input int ch, input bit launch, input int done_at, input int k,
                           input logic [RW-1:0] resp);
    logic [N-1:0] mask;
    mask = N'($urandom);
    if (launch) mask[ch] = (done_at > 0) && ((k - 2) >= done_at);
    bus.PUF_DONE = mask;
    for (int c = 0; c < N; c++) bus.PUF_RESP[c*RW +: RW] = rnd128();
    if (ch < N) bus.PUF_RESP[ch*RW +: RW] = resp;
  endtask

  // One command: expected reply derived from the command rules, then observed cycle by cycle
  task automatic do_cmd(input logic [7:0] op, input logic [15:0] cnt, input int done_at,
                        input logic [RW-1:0] resp, input int n_ovr, input bit rx_in_reply);
    int cmd, ch, lat, k, issued, obs_lat;
    logic [7:0]    st;
    logic [RW-1:0] pay;
    logic [FW-1:0] obs_frame, exp_frame;
    logic [N-1:0]  exp_start;
    logic [RW-1:0] mid;
    bit launch, got, start_ok, start_bad;

    cmd = int'(op[7:4]);
    ch  = int'(op[3:0]);
    launch = 1'b0; pay = '0; lat = 2; exp_start = '0;
    if (cmd < 1 || cmd > 3)                 st = 8'hE1;
    else if (cmd != 3 && ch >= N)           st = 8'hE2;
    else if (cmd == 1 && cnt == 16'h0)      st = 8'hE4;
    else if (cmd == 2 && !m_valid[ch])      st = 8'hE5;
    else if (cmd == 2) begin st = op; pay = m_bank[ch]; end
    else if (cmd == 3) begin
      st = op;
      for (int c = 0; c < N; c++) pay[c] = m_valid[c];
      pay[N +: 8] = 8'(m_ovr);
    end else begin
      launch    = 1'b1;
      exp_start = N'(1) << ch;
      if (done_at >= 1 && done_at <= TMO) begin st = op; pay = resp; lat = done_at + 3; end
      else begin st = 8'hE3; lat = TMO + 3; end
    end
    exp_frame = {st, pay};

    mid = rnd128();
    bus.RX_FRAME = {op, mid[RW-CW-1:0], cnt};
    bus.RX_VALID = 1'b1;
    drive_puf(ch, launch, done_at, 0, resp);
    got = 1'b0; k = 0; issued = 0; obs_lat = 0; obs_frame = '0;
    start_ok = !launch; start_bad = 1'b0;

    while (!got && k < TMO + 12) begin
      @(posedge CLK); #1;
      k++;
      bus.RX_VALID = 1'b0;
      bus.RX_FRAME = {rnd128(), 8'($urandom)};
      if (bus.PUF_START != '0) begin
        if (launch && k == 2 && bus.PUF_START == exp_start) start_ok = 1'b1;
        else start_bad = 1'b1;
      end
      if (k == 1) chk("busy_run", FW'(bus.BUSY), FW'(1));
      if (k == 2 && launch) chk("puf_cnt_run", FW'(bus.PUF_CNT), FW'(cnt));
      if (bus.TX_VALID) begin
        got = 1'b1; obs_lat = k; obs_frame = bus.TX_FRAME;
        if (rx_in_reply) begin bus.RX_VALID = 1'b1; issued++; end
      end else begin
        if (issued < n_ovr && k >= 3 && (k % 2) == 1) begin bus.RX_VALID = 1'b1; issued++; end
        drive_puf(ch, launch, done_at, k, resp);
      end
    end

    chk("latency", FW'(obs_lat), FW'(lat));
    chk("reply_frame", obs_frame, exp_frame);
    chk("puf_start", FW'({start_ok, start_bad}), FW'(2'b10));

    @(posedge CLK); #1;
    bus.RX_VALID = 1'b0;
    bus.PUF_DONE = '0;
    chk("busy_after", FW'(bus.BUSY), FW'(0));
    chk("txv_after", FW'(bus.TX_VALID), FW'(0));
    chk("tx_hold", bus.TX_FRAME, exp_frame);
    chk("puf_cnt_after", FW'(bus.PUF_CNT), FW'(1));

    if (cmd == 1 && st == op) begin m_bank[ch] = resp; m_valid[ch] = 1'b1; end
    if (cmd == 3) m_ovr = 0;
    m_ovr = (m_ovr + issued > 255) ? 255 : m_ovr + issued;
  endtask

  initial begin
    logic [RW-1:0] resp_a;
    logic [7:0]    op;
    logic [15:0]   cnt;
    int sel, c;

    RESET = 1'b1;
    bus.RX_VALID = 1'b0;
    bus.RX_FRAME = '0;
    bus.PUF_DONE = '0;
    bus.PUF_RESP = '0;
    for (int i = 0; i < N; i++) begin m_valid[i] = 1'b0; m_bank[i] = '0; end
    m_ovr = 0;

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busy", FW'(bus.BUSY), FW'(0));
    chk("rst_txv", FW'(bus.TX_VALID), FW'(0));
    chk("rst_txf", bus.TX_FRAME, FW'(0));
    chk("rst_cnt", FW'(bus.PUF_CNT), FW'(1));
    chk("rst_start", FW'(bus.PUF_START), FW'(0));
    RESET = 1'b0;

    resp_a = rnd128();
    do_cmd(8'h11, 16'h0005, 4, resp_a, 0, 1'b0);
    do_cmd(8'h21, 16'h0000, 0, '0, 0, 1'b0);
    do_cmd(8'h20, 16'h0000, 0, '0, 0, 1'b0);
    do_cmd(8'h12, 16'h0001, 1, rnd128(), 0, 1'b0);
    do_cmd(8'h55, 16'h0001, 1, rnd128(), 0, 1'b0);
    do_cmd(8'h10, 16'h0000, 1, rnd128(), 0, 1'b0);

    // Timeout leaves channel 0 without a response; DONE in the last WAIT cycle still wins
    do_cmd(8'h10, 16'h0003, 0, rnd128(), 0, 1'b0);
    do_cmd(8'h20, 16'h0000, 0, '0, 0, 1'b0);
    do_cmd(8'h10, 16'h0007, TMO, rnd128(), 0, 1'b0);
    do_cmd(8'h10, 16'h0009, TMO + 1, rnd128(), 0, 1'b0);
    do_cmd(8'h20, 16'h0000, 0, '0, 0, 1'b0);

    do_cmd(8'h30, 16'h0000, 0, '0, 0, 1'b0);
    do_cmd(8'h11, 16'h0002, 6, rnd128(), 3, 1'b0);
    do_cmd(8'h30, 16'h0000, 0, '0, 0, 1'b0);
    do_cmd(8'h30, 16'h0000, 0, '0, 0, 1'b0);
    do_cmd(8'h21, 16'h0000, 0, '0, 0, 1'b1);
    do_cmd(8'h30, 16'h0000, 0, '0, 0, 1'b0);

    // Reset while a run is in WAIT
    bus.RX_FRAME = {8'h10, 112'h0, 16'h0003};
    bus.RX_VALID = 1'b1;
    bus.PUF_DONE = '0;
    @(posedge CLK); #1;
    bus.RX_VALID = 1'b0;
    repeat (4) begin @(posedge CLK); #1; end
    chk("busy_pre_rst", FW'(bus.BUSY), FW'(1));
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    chk("mid_rst_busy", FW'(bus.BUSY), FW'(0));
    chk("mid_rst_start", FW'(bus.PUF_START), FW'(0));
    chk("mid_rst_txf", bus.TX_FRAME, FW'(0));
    chk("mid_rst_cnt", FW'(bus.PUF_CNT), FW'(1));
    for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
    m_ovr = 0;
    do_cmd(8'h20, 16'h0000, 0, '0, 0, 1'b0);
    do_cmd(8'h30, 16'h0000, 0, '0, 0, 1'b0);

    for (int i = 0; i < 80; i++) begin
      sel = $urandom_range(0, 9);
      cnt = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      case (sel)
        0, 1, 2, 3: op = {4'h1, 4'($urandom_range(0, N))};
        4, 5:       op = {4'h2, 4'($urandom_range(0, N))};
        6:          op = {4'h3, 4'($urandom)};
        7: begin
          c = $urandom_range(4, 16);
          op = {4'(c == 16 ? 0 : c), 4'($urandom)};
        end
        8:          op = 8'($urandom);
        default: begin op = {4'h1, 4'($urandom_range(0, N - 1))}; cnt = 16'h1; end
      endcase
      do_cmd(op, cnt, $urandom_range(0, TMO + 2), rnd128(), $urandom_range(0, 3),
             $urandom_range(0, 3) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
